// File: rtl/fp_mult_pkg.sv
// Shared definitions for the pipelined floating-point multiplier: field widths,
// operand classes, flag bit positions and special-value encodings.
package fp_mult_pkg;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_SUB,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  localparam int FLG_INX = 0;
  localparam int FLG_UNF = 1;
  localparam int FLG_OVF = 2;
  localparam int FLG_INV = 3;

  function automatic int width_f(int exp_w, int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int bias_f(int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // All-ones exponent: reserved for Inf/NaN, first overflowing value.
  function automatic int emax_f(int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic logic [63:0] qnan_f(int exp_w, int man_w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
    r[man_w - 1] = 1'b1;
    return r;
  endfunction

  // Magnitude only; the caller supplies the sign bit.
  function automatic logic [63:0] max_finite_f(int exp_w, int man_w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < man_w; i++) r[i] = 1'b1;
    for (int i = 1; i < exp_w; i++) r[man_w + i] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fp_mult_round.sv
// Final multiplier stage logic: normalise the raw mantissa product, round to
// nearest-even, detect overflow/underflow and pack the result with its flags.
module fp_mult_round
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int SAT   = 0
) (
  input  logic [2*MAN_W+1:0]     prod_i,
  input  logic signed [EXP_W+1:0] exp_i,
  input  logic                   sign_i,
  input  logic [2:0]             cls_i,
  input  logic                   invalid_i,
  output logic [EXP_W+MAN_W:0]   result_o,
  output logic [3:0]             flags_o
);

  localparam int W  = width_f(EXP_W, MAN_W);
  localparam int PW = 2 * (MAN_W + 1);
  localparam int RW = EXP_W + 3 + MAN_W;
  localparam logic [W-1:0]     QNAN     = W'(qnan_f(EXP_W, MAN_W));
  localparam logic [W-2:0]     MAXF     = (W-1)'(max_finite_f(EXP_W, MAN_W));
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  int                 lz, sh, exp_pre;
  logic [PW-1:0]      norm, lost_mask;
  logic [MAN_W-1:0]   man;
  logic               guard, sticky, tiny, inexact, rnd_up, ovf;
  logic [RW-1:0]      rounded;
  logic [EXP_W+2:0]   exp_r;

  always_comb begin
    lz = PW;
    for (int i = 0; i < PW; i++)
      if (prod_i[i]) lz = PW - 1 - i;

    // Shift so the leading one reaches the top, but never below exponent 1;
    // a negative shift pushes tiny results right into the subnormal range.
    sh = (int'(exp_i) < lz) ? int'(exp_i) : lz;
    lost_mask = '0;
    if (sh >= 0) begin
      norm = prod_i << sh;
    end else if (-sh >= PW) begin
      norm      = '0;
      lost_mask = '1;
    end else begin
      norm      = prod_i >> (-sh);
      lost_mask = ~({PW{1'b1}} << (-sh));
    end

    tiny    = ~norm[PW-1];
    exp_pre = tiny ? 0 : int'(exp_i) + 1 - lz;
    man     = norm[PW-2 -: MAN_W];
    guard   = norm[MAN_W];
    sticky  = (|norm[MAN_W-1:0]) | (|(prod_i & lost_mask));
    inexact = guard | sticky;
    rnd_up  = guard & (sticky | man[0]);
    // Carry out of the mantissa lands in the exponent field directly.
    rounded = {(EXP_W+3)'(exp_pre), man} + RW'(rnd_up);
    exp_r   = rounded[RW-1:MAN_W];
    ovf     = exp_r >= (EXP_W+3)'(emax_f(EXP_W));

    result_o = '0;
    flags_o  = '0;
    case (fp_class_e'(cls_i))
      CLS_NAN: begin
        result_o         = QNAN;
        flags_o[FLG_INV] = invalid_i;
      end
      CLS_INF:  result_o = {sign_i, EXP_ONES, {MAN_W{1'b0}}};
      CLS_ZERO: result_o = {sign_i, {(W-1){1'b0}}};
      default: begin
        if (ovf) begin
          result_o = (SAT != 0) ? {sign_i, MAXF} : {sign_i, EXP_ONES, {MAN_W{1'b0}}};
          flags_o[FLG_OVF] = 1'b1;
          flags_o[FLG_INX] = 1'b1;
        end else begin
          result_o = {sign_i, exp_r[EXP_W-1:0], rounded[MAN_W-1:0]};
          flags_o[FLG_UNF] = tiny & inexact;
          flags_o[FLG_INX] = inexact;
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with a single global advance
// enable for valid/ready backpressure: unpack/classify, multiply, round/pack.
module fp_mult_pipe
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int SAT   = 0,
  parameter int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] data1,
  input  logic [W-1:0] data2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int EW   = EXP_W + 2;
  localparam int PW   = 2 * (MAN_W + 1);
  localparam int BIAS = bias_f(EXP_W);

  logic             adv;
  logic             v1_q, v2_q, out_valid_q;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  fp_class_e        cls_a, cls_b, cls1_d, cls1_q, cls2_q;
  logic             inv1_d, inv1_q, inv2_q, sign1_q, sign2_q;
  logic [EXP_W-1:0] e1a_q, e1b_q;
  logic [MAN_W:0]   m1a_q, m1b_q;
  logic [PW-1:0]    prod2_q;
  logic signed [EW-1:0] exp2_q;
  logic [W-1:0]     result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  function automatic fp_class_e classify(logic [EXP_W-1:0] e, logic [MAN_W-1:0] f);
    if (e == '0) return (f == '0) ? CLS_ZERO : CLS_SUB;
    if (e == '1) return (f == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;
  assign ea = data1[W-2 -: EXP_W];
  assign eb = data2[W-2 -: EXP_W];
  assign fa = data1[MAN_W-1:0];
  assign fb = data2[MAN_W-1:0];

  // Special-case priority is resolved once here and carried as a result class.
  always_comb begin
    cls_a  = classify(ea, fa);
    cls_b  = classify(eb, fb);
    inv1_d = 1'b0;
    if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
      cls1_d = CLS_NAN;
    end else if ((cls_a == CLS_INF && cls_b == CLS_ZERO) ||
                 (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
      cls1_d = CLS_NAN;
      inv1_d = 1'b1;
    end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
      cls1_d = CLS_INF;
    end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
      cls1_d = CLS_ZERO;
    end else begin
      cls1_d = CLS_NORM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else if (adv) begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      if (v2_q) begin
        result_q <= result_d;
        flags_q  <= flags_d;
      end
    end
  end

  // Datapath registers carry no reset; only the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (adv) begin
      sign1_q <= data1[W-1] ^ data2[W-1];
      cls1_q  <= cls1_d;
      inv1_q  <= inv1_d;
      e1a_q   <= (ea == '0) ? EXP_W'(1) : ea;
      e1b_q   <= (eb == '0) ? EXP_W'(1) : eb;
      m1a_q   <= {ea != '0, fa};
      m1b_q   <= {eb != '0, fb};
      sign2_q <= sign1_q;
      cls2_q  <= cls1_q;
      inv2_q  <= inv1_q;
      prod2_q <= PW'(m1a_q) * PW'(m1b_q);
      exp2_q  <= EW'(e1a_q) + EW'(e1b_q) - EW'(BIAS);
    end
  end

  fp_mult_round #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W),
    .SAT  (SAT)
  ) u_round (
    .prod_i   (prod2_q),
    .exp_i    (exp2_q),
    .sign_i   (sign2_q),
    .cls_i    (cls2_q),
    .invalid_i(inv2_q),
    .result_o (result_d),
    .flags_o  (flags_d)
  );

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboard bench for fp_mult_pipe in FP16: a SAT=0 and a SAT=1 copy share
// stimulus; a value-level reference model supplies expected products.
module tb_fp_mult_pipe;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int W     = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] data1 = '0, data2 = '0;
  logic         in_ready0, in_ready1, out_valid0, out_valid1;
  logic [W-1:0] result0, result1;
  logic [3:0]   flags0, flags1;

  always #5 clk = ~clk;

  fp_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .SAT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .data1(data1), .data2(data2), .out_valid(out_valid0), .out_ready(out_ready),
    .result(result0), .flags(flags0));

  fp_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .SAT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .data1(data1), .data2(data2), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .flags(flags1));

  typedef struct {
    logic [15:0] a, b, r0, r1;
    logic [3:0]  f;
    int          acc_cyc;
    bit          lat_chk;
  } item_t;

  typedef struct packed {
    logic [15:0] r0;
    logic [15:0] r1;
    logic [3:0]  f;
  } exp_t;

  item_t sbq[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc   = 0;
  bit    rnd_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference: exact product P*2^k rounded onto the representable grid.
  function automatic exp_t model(logic [15:0] a, logic [15:0] b);
    exp_t   o;
    logic   s;
    int     ea, eb, k, hb, x, qe, d, fld;
    longint ma, mb, p, q, rem, half;
    bit     anan, bnan, ainf, binf, azero, bzero, inx, tiny;
    s = a[15] ^ b[15];
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    anan  = (ea == 31) && (a[9:0] != 0);
    bnan  = (eb == 31) && (b[9:0] != 0);
    ainf  = (ea == 31) && (a[9:0] == 0);
    binf  = (eb == 31) && (b[9:0] == 0);
    azero = (ea == 0) && (a[9:0] == 0);
    bzero = (eb == 0) && (b[9:0] == 0);
    o = '0;
    if (anan || bnan) begin
      o.r0 = 16'h7E00;
    end else if ((ainf && bzero) || (azero && binf)) begin
      o.r0 = 16'h7E00;
      o.f  = 4'b1000;
    end else if (ainf || binf) begin
      o.r0 = {s, 5'h1F, 10'h0};
    end else if (azero || bzero) begin
      o.r0 = {s, 15'h0};
    end else begin
      ma = (ea == 0) ? longint'(a[9:0]) : longint'(a[9:0]) + 1024;
      mb = (eb == 0) ? longint'(b[9:0]) : longint'(b[9:0]) + 1024;
      if (ea == 0) ea = 1;
      if (eb == 0) eb = 1;
      p = ma * mb;
      k = ea + eb - 30 - 20;
      hb = 0;
      for (int i = 0; i < 48; i++) if (p[i]) hb = i;
      x    = hb + k;
      tiny = (x + 15) < 1;
      qe   = tiny ? -24 : x - 10;
      d    = qe - k;
      inx  = 0;
      if (d <= 0) begin
        q = p << (-d);
      end else begin
        q    = p >> d;
        rem  = p & ((longint'(1) << d) - 1);
        half = longint'(1) << (d - 1);
        inx  = (rem != 0);
        if (rem > half || (rem == half && q[0])) q = q + 1;
      end
      if (tiny) begin
        o.r0 = {s, 15'(q)};
        o.f  = {2'b00, inx, inx};
      end else begin
        if (q == 2048) begin
          q  = 1024;
          qe = qe + 1;
        end
        fld = qe + 25;
        if (fld >= 31) begin
          o.r0 = {s, 5'h1F, 10'h0};
          o.r1 = {s, 5'h1E, 10'h3FF};
          o.f  = 4'b0101;
          return o;
        end
        o.r0 = {s, 5'(fld), 10'(q)};
        o.f  = {3'b000, inx};
      end
    end
    o.r1 = o.r0;
    return o;
  endfunction

  function automatic logic [15:0] rnd_op();
    logic       s;
    logic [4:0] e;
    logic [9:0] m;
    s = 1'($urandom);
    m = 10'($urandom);
    case ($urandom_range(0, 15))
      0:       begin e = 5'd0; m = 10'd0; end
      1:       begin e = 5'h1F; m = 10'd0; end
      2:       begin e = 5'h1F; if (m == 0) m = 10'd1; end
      3, 4:    e = 5'd0;
      5, 6:    e = 5'($urandom_range(24, 30));
      7, 8:    e = 5'($urandom_range(1, 6));
      default: e = 5'($urandom_range(1, 30));
    endcase
    return {s, e, m};
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r0,
                       input logic [15:0] r1, input logic [3:0] f, input bit lat);
    item_t it;
    int    w;
    in_valid = 1'b1;
    data1    = a;
    data2    = b;
    w = 0;
    @(negedge clk);
    while (!in_ready0 && w < 200) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready0) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout %h*%h: in_ready stayed 0, required 1", a, b);
    end else begin
      it.a = a; it.b = b; it.r0 = r0; it.r1 = r1; it.f = f;
      it.acc_cyc = cyc;
      it.lat_chk = lat;
      sbq.push_back(it);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic issue_rand(input bit lat);
    logic [15:0] a, b;
    exp_t        e;
    a = rnd_op();
    b = rnd_op();
    e = model(a, b);
    issue(a, b, e.r0, e.r1, e.f, lat);
  endtask

  task automatic drain();
    int w;
    w = 0;
    out_ready = 1'b1;
    while (sbq.size() != 0 && w < 300) begin
      w++;
      @(posedge clk);
    end
    repeat (5) @(posedge clk);
    #1;
    chk("drain_pending", sbq.size(), 0);
  endtask

  // Monitor: pops on every transfer, checks hold-stability while stalled.
  initial begin : monitor
    item_t       it;
    bit          held;
    logic [15:0] held_r;
    logic [3:0]  held_f;
    held = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0;
      end else begin
        if (held) begin
          chk("hold_valid", out_valid0, 1);
          chk("hold_result", result0, held_r);
          chk("hold_flags", flags0, held_f);
        end
        if (out_valid0 && out_ready) begin
          held = 0;
          if (sbq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: got %h with nothing expected", result0);
          end else begin
            it = sbq.pop_front();
            chk($sformatf("result_sat0 %h*%h", it.a, it.b), result0, it.r0);
            chk($sformatf("result_sat1 %h*%h", it.a, it.b), result1, it.r1);
            chk($sformatf("flags_sat0 %h*%h", it.a, it.b), flags0, it.f);
            chk($sformatf("flags_sat1 %h*%h", it.a, it.b), flags1, it.f);
            chk("valid_sat1", out_valid1, 1);
            if (it.lat_chk) chk($sformatf("latency %h*%h", it.a, it.b), cyc - it.acc_cyc, 3);
          end
        end else if (out_valid0) begin
          held   = 1;
          held_r = result0;
          held_f = flags0;
        end else begin
          held = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

  initial begin : main
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid0, 0);
    chk("reset_result", result0, 0);
    chk("reset_flags", flags0, 0);
    chk("reset_in_ready", in_ready0, 1);
    rst = 1'b0;

    // Directed cases with known encodings, consumer always ready.
    out_ready = 1'b1;
    issue(16'h3C00, 16'h4000, 16'h4000, 16'h4000, 4'b0000, 1);
    issue(16'h3C01, 16'h3C01, 16'h3C02, 16'h3C02, 4'b0001, 1);
    issue(16'h7BFF, 16'h4000, 16'h7C00, 16'h7BFF, 4'b0101, 1);
    issue(16'h0001, 16'h3800, 16'h0000, 16'h0000, 4'b0011, 1);
    issue(16'h0001, 16'h3C00, 16'h0001, 16'h0001, 4'b0000, 1);
    issue(16'h8200, 16'h4000, 16'h8400, 16'h8400, 4'b0000, 1);
    issue(16'h7C00, 16'h0000, 16'h7E00, 16'h7E00, 4'b1000, 1);
    issue(16'hFC00, 16'h3C00, 16'hFC00, 16'hFC00, 4'b0000, 1);
    issue(16'h7D00, 16'h3C00, 16'h7E00, 16'h7E00, 4'b0000, 1);
    issue(16'h8000, 16'h3C00, 16'h8000, 16'h8000, 4'b0000, 1);
    drain();

    // Backpressure: six back-to-back operands with the consumer stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue_rand(0);
    @(negedge clk);
    chk("in_ready_stalled", in_ready0, 0);
    chk("in_ready_stalled_sat1", in_ready1, 0);
    @(posedge clk);
    #1;
    fork
      for (int i = 0; i < 3; i++) issue_rand(0);
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with three operands in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue_rand(0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid0, 0);
    chk("midrst_result", result0, 0);
    chk("midrst_flags", flags0, 0);
    chk("midrst_result_sat1", result1, 0);
    sbq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    issue(16'h3C00, 16'h4000, 16'h4000, 16'h4000, 4'b0000, 1);
    drain();

    // Random operands, random gaps and random consumer stalls.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          issue_rand(0);
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
